// File: rtl/ripple_accumulator.sv
// Sums NUM_SAMPLES N-bit samples via a ripple-carry adder; result valid the cycle after the last accept.
// in_ready is state-only (low while holding a result); the result is held until out_ready.

module N_full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module N_ripple_adder #(
  parameter int N = 6
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_in_i,
  output logic [N-1:0] sum_o,
  output logic         carry_out_o
);
  logic [N:0] carry;

  assign carry[0] = carry_in_i;

  for (genvar i = 0; i < N; i++) begin : g_bit
    N_full_adder u_fa (
      .a_i (a_i[i]),
      .b_i (b_i[i]),
      .c_i (carry[i]),
      .s_o (sum_o[i]),
      .c_o (carry[i+1])
    );
  end

  assign carry_out_o = carry[N];
endmodule

module ripple_accumulator #(
  parameter int N           = 6,
  parameter int NUM_SAMPLES = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clear,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [N-1:0]                       in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [N-1:0]                       acc_out,
  output logic                               overflow,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]   count
);
  localparam int CW = $clog2(NUM_SAMPLES+1);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_SAMPLES - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  sum;
  logic          carry_out;

  N_ripple_adder #(.N(N)) u_adder (
    .a_i         (acc_q),
    .b_i         (in_data),
    .carry_in_i  (1'b0),
    .sum_o       (sum),
    .carry_out_o (carry_out)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    in_ready  = (state_q == ACC);
    out_valid = (state_q == HOLD);

    // clear outranks everything, including an accept or a consume in the same cycle
    if (clear) begin
      state_d = ACC;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            acc_d = sum;
            ovf_d = ovf_q | carry_out;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) state_d = HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign acc_out  = acc_q;
  assign overflow = ovf_q;
  assign count    = cnt_q;

endmodule
